// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder that feeds one add4 slice a nibble per clock, LSB nibble first.
// Optional signed-overflow output is enabled by defining OVERFLOW_FLAG_EN.

module add4 (
    output logic [3:0] s,
    output logic       cy4,
    input  logic       cy_in,
    input  logic [3:0] x,
    input  logic [3:0] y
);

    assign {cy4, s} = {1'b0, x} + {1'b0, y} + {4'b0000, cy_in};

endmodule

module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef OVERFLOW_FLAG_EN
    ,
    output logic             ovf
`endif
);

    localparam int NIB  = WIDTH / 4;
    localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NIB - 1);
    localparam logic [IDXW-1:0] IDX_ONE  = IDXW'(1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t                  state_q;
    logic [IDXW-1:0]         idx_q;
    logic                    carry_q;
    logic [NIB-1:0][3:0]     a_q;
    logic [NIB-1:0][3:0]     b_q;
    logic [NIB-1:0][3:0]     sum_q;
    logic                    cout_q;
    logic                    out_valid_q;
    logic                    in_ready_q;
`ifdef OVERFLOW_FLAG_EN
    logic                    ovf_q;
`endif

    logic [3:0] sliceX;
    logic [3:0] sliceY;
    logic [3:0] sliceS;
    logic       sliceCy4;

    assign sliceX = a_q[idx_q];
    assign sliceY = b_q[idx_q];

    add4 u_add4 (
        .s     (sliceS),
        .cy4   (sliceCy4),
        .cy_in (carry_q),
        .x     (sliceX),
        .y     (sliceY)
    );

    // One nibble per RUN edge; the last nibble also latches cout (and ovf) and presents the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
`ifdef OVERFLOW_FLAG_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q        <= a;
                        b_q        <= b;
                        carry_q    <= cin;
                        idx_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    sum_q[idx_q] <= sliceS;
                    carry_q      <= sliceCy4;
                    if (idx_q == IDX_LAST) begin
                        idx_q       <= '0;
                        cout_q      <= sliceCy4;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
`ifdef OVERFLOW_FLAG_EN
                        // Carry into the MSB recovered from the slice sum bit, XORed with carry out.
                        ovf_q <= a_q[NIB-1][3] ^ b_q[NIB-1][3] ^ sliceS[3] ^ sliceCy4;
`endif
                    end else begin
                        idx_q <= idx_q + IDX_ONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
`ifdef OVERFLOW_FLAG_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder (WIDTH=16); expected results come from plain integer addition.
// Define OVERFLOW_FLAG_EN for both files to exercise the ovf output.

module tb_nibble_serial_adder;

    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             cin = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef OVERFLOW_FLAG_EN
    logic             ovf;
`endif

    int checkCount = 0;
    int errorCount = 0;

    always #5 clk = ~clk;

    nibble_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef OVERFLOW_FLAG_EN
        ,
        .ovf       (ovf)
`endif
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // One full transaction: accept, latency count, result check, optional back-pressure with noisy inputs, release.
    task automatic applyStimulus(input logic [WIDTH-1:0] opA, input logic [WIDTH-1:0] opB,
                                 input logic opCin, input int holdCycles);
        logic [WIDTH:0]   total;
        logic [WIDTH-1:0] expSum;
        logic             expCout;
        logic             expOvf;
        int               edges;

        total   = {1'b0, opA} + {1'b0, opB} + {{WIDTH{1'b0}}, opCin};
        expSum  = total[WIDTH-1:0];
        expCout = total[WIDTH];
        expOvf  = (opA[WIDTH-1] == opB[WIDTH-1]) && (expSum[WIDTH-1] != opA[WIDTH-1]);

        checkOutput("in_ready_idle", {31'd0, in_ready}, 32'd1);
        a        = opA;
        b        = opB;
        cin      = opCin;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a        = WIDTH'($urandom);
        b        = WIDTH'($urandom);
        cin      = 1'($urandom);
        checkOutput("in_ready_run", {31'd0, in_ready}, 32'd0);

        edges = 0;
        while (!out_valid && edges < 20) begin
            @(posedge clk); #1;
            edges++;
        end
        checkOutput("latency", edges, 32'd4);
        checkOutput("sum", {16'd0, sum}, {16'd0, expSum});
        checkOutput("cout", {31'd0, cout}, {31'd0, expCout});
`ifdef OVERFLOW_FLAG_EN
        checkOutput("ovf", {31'd0, ovf}, {31'd0, expOvf});
`else
        if (expOvf === 1'bx) $display("[TB] note: unexpected X in overflow model");
`endif

        for (int i = 0; i < holdCycles; i++) begin
            in_valid = 1'b1;
            a        = WIDTH'($urandom);
            b        = WIDTH'($urandom);
            cin      = 1'($urandom);
            @(posedge clk); #1;
            checkOutput("hold_sum", {16'd0, sum}, {16'd0, expSum});
            checkOutput("hold_cout", {31'd0, cout}, {31'd0, expCout});
            checkOutput("hold_in_ready", {31'd0, in_ready}, 32'd0);
            checkOutput("hold_out_valid", {31'd0, out_valid}, 32'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checkOutput("release_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("release_in_ready", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        int validSeen;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("reset_sum", {16'd0, sum}, 32'd0);
        checkOutput("reset_cout", {31'd0, cout}, 32'd0);
        checkOutput("reset_in_ready", {31'd0, in_ready}, 32'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        applyStimulus(16'h1234, 16'h4321, 1'b0, 0);
        applyStimulus(16'hFFFF, 16'h0001, 1'b0, 0);
        applyStimulus(16'hFFFF, 16'hFFFF, 1'b1, 0);
        applyStimulus(16'h7FFF, 16'h0001, 1'b0, 0);
        applyStimulus(16'h8000, 16'h8000, 1'b0, 0);
        applyStimulus(16'hA5A5, 16'h0F0F, 1'b1, 5);

        // Abort an operation after two RUN edges.
        a        = 16'h1111;
        b        = 16'h2222;
        cin      = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("abort_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("abort_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("abort_sum", {16'd0, sum}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        validSeen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (out_valid) validSeen++;
        end
        checkOutput("abort_no_result", validSeen, 32'd0);
        applyStimulus(16'h000F, 16'h0001, 1'b0, 0);

        for (int n = 0; n < 40; n++) begin
            applyStimulus(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
